lut_ff_mux_array: RTL and testbench

Parametrised multi-channel successor to the single LUT/FF/mux cell. Provides NCH independent K-input LUTs, each followed by a flip-flop and an output mux that selects the registered or combinational result. LUT truth tables are loaded at run time through a valid/ready configuration stream into a shadow register, then committed atomically. It sits in the lut_ff_mux benchmark family as the programmable-logic test block for pre- and post-route equivalence benches.

---
 rtl/lut_ff_mux_pkg.sv | 32 +++
 rtl/lut_ff_mux_cell.sv | 36 +++
 rtl/lut_ff_mux_array.sv | 122 ++++++++++++
 tb/tb_lut_ff_mux_array.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_ff_mux_pkg.sv
// lut_ff_mux_pkg: shared state encoding and size helpers for the LUT/FF/mux array.
// Rev 1.0
`default_nettype none

package lut_ff_mux_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      COMMIT = 2'd2
   } cfg_state_t;

   function automatic int mask_w(input int k);
      return 1 << k;
   endfunction

   function automatic int cfg_bits(input int nch, input int k);
      return nch * mask_w(k);
   endfunction

   function automatic int beats(input int nch, input int k, input int cfg_w);
      return cfg_bits(nch, k) / cfg_w;
   endfunction

   // Beats must tile the mask vector exactly, otherwise the shadow packing breaks.
   function automatic bit cfg_w_ok(input int nch, input int k, input int cfg_w);
      return (cfg_w > 0) && ((cfg_bits(nch, k) % cfg_w) == 0);
   endfunction

endpackage

`default_nettype wire

// File: rtl/lut_ff_mux_cell.sv
// lut_ff_mux_cell: one K-input LUT, its flip-flop and the registered/combinational output mux.
// Rev 1.0
`default_nettype none

module lut_ff_mux_cell
   import lut_ff_mux_pkg::*;
#(
   parameter int K = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [mask_w(K)-1:0] mask,
   input  logic [K-1:0]         in,
   input  logic                 ce,
   input  logic                 mux_sel,
   output logic                 q
);

   logic lut;
   logic ff;

   assign lut = mask[in];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ff <= 1'b0;
      end else if (ce) begin
         ff <= lut;
      end
   end

   assign q = mux_sel ? ff : lut;

endmodule

`default_nettype wire

// File: rtl/lut_ff_mux_array.sv
// lut_ff_mux_array: NCH run-time programmable LUT/FF/mux channels with a double-buffered
// configuration stream. Rev 1.0
`default_nettype none

module lut_ff_mux_array
   import lut_ff_mux_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int K     = 4,
   parameter int CFG_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NCH*K-1:0]   in,
   input  logic [NCH-1:0]     mux_sel,
   input  logic               ce,
   input  logic               cfg_start,
   input  logic               cfg_valid,
   input  logic [CFG_W-1:0]   cfg_data,
   output logic               cfg_ready,
   output logic               cfg_done,
   output logic               configured,
   output logic [NCH-1:0]     Q
);

   localparam int MASK_W   = mask_w(K);
   localparam int CFG_BITS = cfg_bits(NCH, K);
   localparam int BEATS    = beats(NCH, K, CFG_W);
   localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;

   if (!cfg_w_ok(NCH, K, CFG_W)) begin : g_cfg_w_check
      $error("lut_ff_mux_array: CFG_W must divide NCH*2^K");
   end

   cfg_state_t          state;
   cfg_state_t          next_state;
   logic [CNT_W-1:0]    cnt;
   logic [CFG_BITS-1:0] shadow;
   logic [CFG_BITS-1:0] active;
   logic                beat_acc;
   logic                last_beat;

   // A restart in LOAD wins over a beat presented in the same cycle.
   assign beat_acc  = cfg_ready && cfg_valid && !cfg_start;
   assign last_beat = beat_acc && (cnt == CNT_W'(BEATS - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      cfg_ready  = 1'b0;
      case (state)
         IDLE: begin
            if (cfg_start) begin
               next_state = LOAD;
            end
         end
         LOAD: begin
            cfg_ready = 1'b1;
            if (last_beat) begin
               next_state = COMMIT;
            end
         end
         COMMIT: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt    <= '0;
         shadow <= '0;
      end else if (cfg_start && (state == IDLE || state == LOAD)) begin
         cnt <= '0;
      end else if (beat_acc) begin
         cnt    <= cnt + CNT_W'(1);
         shadow <= (shadow << CFG_W) | CFG_BITS'(cfg_data);
      end
   end

   // LUTs keep the old masks until the commit edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         active     <= '0;
         cfg_done   <= 1'b0;
         configured <= 1'b0;
      end else if (state == COMMIT) begin
         active     <= shadow;
         cfg_done   <= 1'b1;
         configured <= 1'b1;
      end else begin
         cfg_done   <= 1'b0;
      end
   end

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      lut_ff_mux_cell #(
         .K (K)
      ) u_cell (
         .clk     (clk),
         .rst     (rst),
         .mask    (active[c*MASK_W +: MASK_W]),
         .in      (in[c*K +: K]),
         .ce      (ce),
         .mux_sel (mux_sel[c]),
         .q       (Q[c])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_lut_ff_mux_array.sv
// tb_lut_ff_mux_array: randomized scenarios checked against a mask/flip-flop reference model.
// Rev 1.0
`default_nettype none

module tb_lut_ff_mux_array;

   logic        clk;
   logic        rst;
   logic [15:0] in;
   logic [3:0]  mux_sel;
   logic        ce;
   logic        cfg_start;
   logic        cfg_valid;
   logic [7:0]  cfg_data;
   logic        cfg_ready;
   logic        cfg_done;
   logic        configured;
   logic [3:0]  Q;

   int total = 0;
   int bad   = 0;

   // Reference state: active masks as seen by the LUTs, and the per-channel flip-flops.
   logic [15:0] m_mask [4];
   logic [3:0]  m_ff;

   lut_ff_mux_array #(
      .NCH   (4),
      .K     (4),
      .CFG_W (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in         (in),
      .mux_sel    (mux_sel),
      .ce         (ce),
      .cfg_start  (cfg_start),
      .cfg_valid  (cfg_valid),
      .cfg_data   (cfg_data),
      .cfg_ready  (cfg_ready),
      .cfg_done   (cfg_done),
      .configured (configured),
      .Q          (Q)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [3:0] exp_q();
      logic [3:0] e;
      for (int c = 0; c < 4; c++) begin
         e[c] = mux_sel[c] ? m_ff[c] : m_mask[c][in[c*4 +: 4]];
      end
      return e;
   endfunction

   function automatic void model_set(input logic [63:0] v);
      for (int c = 0; c < 4; c++) m_mask[c] = v[c*16 +: 16];
   endfunction

   function automatic void model_clear();
      for (int c = 0; c < 4; c++) m_mask[c] = 16'h0;
      m_ff = 4'h0;
   endfunction

   // One clock edge; model flip-flops capture with the masks active before the edge.
   task automatic tick();
      if (ce && rst) begin
         for (int c = 0; c < 4; c++) m_ff[c] = m_mask[c][in[c*4 +: 4]];
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      cfg_start = 1'b1;
      cfg_valid = 1'b0;
      tick();
      cfg_start = 1'b0;
   endtask

   // Full load from IDLE (or restart from LOAD); v is the packed mask vector, first beat = MSBs.
   task automatic load_masks(input logic [63:0] v, input int gap_pct, output int dones);
      int gaps;
      dones = 0;
      pulse_start();
      for (int i = 0; i < 8; i++) begin
         gaps = 0;
         while ($urandom_range(99) < gap_pct && gaps < 4) begin
            cfg_valid = 1'b0;
            cfg_data  = 8'($urandom);
            in        = 16'($urandom);
            mux_sel   = 4'($urandom);
            ce        = 1'($urandom);
            #1;
            total++;
            if (Q !== exp_q()) begin
               bad++;
               $display("FAIL load_gap_q beat=%0d got=%b want=%b", i, Q, exp_q());
            end
            tick();
            dones += int'(cfg_done);
            gaps++;
         end
         cfg_valid = 1'b1;
         cfg_data  = v[63-8*i -: 8];
         in        = 16'($urandom);
         mux_sel   = 4'($urandom);
         ce        = 1'($urandom);
         #1;
         total++;
         if (cfg_ready !== 1'b1 || Q !== exp_q()) begin
            bad++;
            $display("FAIL load_beat beat=%0d ready=%b q=%b want_ready=1 want_q=%b",
                     i, cfg_ready, Q, exp_q());
         end
         tick();
         dones += int'(cfg_done);
      end
      cfg_valid = 1'b0;
      tick();
      model_set(v);
      total++;
      if (cfg_done !== 1'b1 || configured !== 1'b1 || dones != 0) begin
         bad++;
         $display("FAIL commit_edge done=%b configured=%b early_dones=%0d want 1 1 0",
                  cfg_done, configured, dones);
      end
      dones += int'(cfg_done);
      tick();
      dones += int'(cfg_done);
      total++;
      if (cfg_done !== 1'b0) begin
         bad++;
         $display("FAIL done_width got=%b want=0", cfg_done);
      end
   endtask

   task automatic test_reset();
      rst       = 1'b0;
      in        = 16'hFFFF;
      mux_sel   = 4'hF;
      ce        = 1'b1;
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
      cfg_data  = 8'h00;
      model_clear();
      #1;
      total++;
      if (Q !== 4'h0 || configured !== 1'b0 || cfg_ready !== 1'b0 || cfg_done !== 1'b0) begin
         bad++;
         $display("FAIL reset_state q=%h configured=%b ready=%b done=%b want all 0",
                  Q, configured, cfg_ready, cfg_done);
      end
      tick();
      tick();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         mux_sel = 4'($urandom);
         #1;
         total++;
         if (Q !== 4'h0 || Q !== exp_q()) begin
            bad++;
            $display("FAIL reset_release q=%h want=0", Q);
         end
      end
   endtask

   task automatic test_load();
      int d;
      load_masks(64'hFF00_AAAA_0001_8000, 0, d);
      total++;
      if (d != 1) begin
         bad++;
         $display("FAIL load_done_count got=%0d want=1", d);
      end
      in      = 16'hF100;
      mux_sel = 4'h0;
      #1;
      total++;
      if (Q !== exp_q()) begin
         bad++;
         $display("FAIL load_comb_f100 got=%b want=%b", Q, exp_q());
      end
   endtask

   task automatic test_registered();
      logic [3:0] held;
      mux_sel = 4'hF;
      ce      = 1'b1;
      in      = 16'($urandom);
      tick();
      total++;
      if (Q !== exp_q()) begin
         bad++;
         $display("FAIL reg_capture got=%b want=%b", Q, exp_q());
      end
      for (int i = 0; i < 4; i++) begin
         in = 16'($urandom);
         #1;
         total++;
         if (Q !== exp_q()) begin
            bad++;
            $display("FAIL reg_before_edge got=%b want=%b", Q, exp_q());
         end
         tick();
         total++;
         if (Q !== exp_q()) begin
            bad++;
            $display("FAIL reg_after_edge got=%b want=%b", Q, exp_q());
         end
      end
      ce   = 1'b0;
      held = m_ff;
      for (int i = 0; i < 4; i++) begin
         in = 16'($urandom);
         tick();
         total++;
         if (Q !== held || Q !== exp_q()) begin
            bad++;
            $display("FAIL reg_hold got=%b want=%b", Q, held);
         end
      end
   endtask

   task automatic test_gaps();
      int d;
      logic [63:0] v;
      v = {$urandom, $urandom};
      load_masks(v, 40, d);
      load_masks(64'hFF00_AAAA_0001_8000, 50, d);
      total++;
      if (d != 1) begin
         bad++;
         $display("FAIL gaps_done_count got=%0d want=1", d);
      end
      mux_sel = 4'h0;
      for (int idx = 0; idx < 16; idx++) begin
         in = {4{4'(idx)}};
         #1;
         total++;
         if (Q !== exp_q()) begin
            bad++;
            $display("FAIL gaps_sweep idx=%0d got=%b want=%b", idx, Q, exp_q());
         end
      end
   endtask

   task automatic test_restart();
      int d;
      int early;
      logic [63:0] v;
      early = 0;
      pulse_start();
      for (int i = 0; i < 5; i++) begin
         cfg_valid = 1'b1;
         cfg_data  = 8'($urandom);
         tick();
         early += int'(cfg_done);
      end
      v = {$urandom, $urandom};
      load_masks(v, 20, d);
      total++;
      if (d != 1 || early != 0) begin
         bad++;
         $display("FAIL restart_done_count got=%0d early=%0d want=1 0", d, early);
      end
      mux_sel = 4'h0;
      for (int idx = 0; idx < 16; idx++) begin
         in = {4{4'(idx)}};
         #1;
         total++;
         if (Q !== exp_q()) begin
            bad++;
            $display("FAIL restart_sweep idx=%0d got=%b want=%b", idx, Q, exp_q());
         end
      end
   endtask

   task automatic test_reset_midload();
      int d;
      logic [63:0] v;
      pulse_start();
      for (int i = 0; i < 3; i++) begin
         cfg_valid = 1'b1;
         cfg_data  = 8'($urandom);
         tick();
      end
      rst = 1'b0;
      model_clear();
      in      = 16'($urandom);
      mux_sel = 4'($urandom);
      #1;
      total++;
      if (Q !== 4'h0 || cfg_ready !== 1'b0 || configured !== 1'b0) begin
         bad++;
         $display("FAIL midload_reset q=%h ready=%b configured=%b want 0 0 0",
                  Q, cfg_ready, configured);
      end
      tick();
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cfg_valid = 1'b1;
         cfg_data  = 8'($urandom);
         in        = 16'($urandom);
         mux_sel   = 4'($urandom);
         ce        = 1'b1;
         tick();
         total++;
         if (cfg_ready !== 1'b0 || cfg_done !== 1'b0 || Q !== 4'h0 || Q !== exp_q()) begin
            bad++;
            $display("FAIL midload_ignored ready=%b done=%b q=%h want 0 0 0",
                     cfg_ready, cfg_done, Q);
         end
      end
      v = {$urandom, $urandom};
      load_masks(v, 30, d);
      mux_sel = 4'h0;
      for (int idx = 0; idx < 16; idx++) begin
         in = {4{4'(idx)}};
         #1;
         total++;
         if (Q !== exp_q()) begin
            bad++;
            $display("FAIL midload_reload idx=%0d got=%b want=%b", idx, Q, exp_q());
         end
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_registered();
      test_gaps();
      test_restart();
      test_reset_midload();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
